// File: rtl/conv_linebuf_ctrl.sv
// Line-buffer sequencer: streams a raster frame through two row FIFOs (FIFO1 = previous
// row, FIFO0 = row before that) and emits vertical 3-pixel columns from the third row on.
module conv_linebuf_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  f1_wr_en,
    output logic [DATA_WIDTH-1:0] f1_wr_data,
    output logic                  f1_rd_en,
    input  logic [DATA_WIDTH-1:0] f1_rd_data,
    output logic                  f0_wr_en,
    output logic [DATA_WIDTH-1:0] f0_wr_data,
    output logic                  f0_rd_en,
    input  logic [DATA_WIDTH-1:0] f0_rd_data,
    input  logic                  f1_full,
    input  logic                  f1_empty,
    input  logic                  f0_full,
    input  logic                  f0_empty,
    output logic                  col_valid,
    output logic [DATA_WIDTH-1:0] col_top,
    output logic [DATA_WIDTH-1:0] col_mid,
    output logic [DATA_WIDTH-1:0] col_bot,
    output logic [3:0]            col_x,
    output logic [7:0]            row_y,
    output logic                  frame_done,
    output logic                  err
);
    // A row never exceeds the FIFO depth, so the column counter only needs log2(depth) bits.
    localparam int            XW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [7:0]    Y_LAST = 8'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, ROW0, ROW1, STEADY, DONE} state_t;

    state_t                  state_reg;
    logic [XW-1:0]           x_reg;
    logic [7:0]              y_reg;
    logic                    pix_ready_reg;
    logic                    f0_wr_pend_reg;
    logic                    col_valid_reg;
    logic                    frame_done_reg;
    logic                    err_reg;
    logic [DATA_WIDTH-1:0]   col_bot_reg;
    logic [DATA_WIDTH-1:0]   col_top_hold_reg;
    logic [DATA_WIDTH-1:0]   col_mid_hold_reg;
    logic [3:0]              col_x_reg;
    logic [7:0]              row_y_reg;

    logic xfer;
    logic in_steady;
    logic last_row;
    logic err_next;

    always_comb begin
        xfer       = pix_valid & pix_ready_reg;
        in_steady  = (state_reg == STEADY);
        last_row   = (y_reg == Y_LAST);
        // The last row only drains the FIFOs so both are empty when the frame ends.
        f1_wr_en   = xfer & ((state_reg == ROW0) | (state_reg == ROW1) | (in_steady & ~last_row));
        f1_rd_en   = xfer & ((state_reg == ROW1) | in_steady);
        f0_rd_en   = xfer & in_steady;
        f0_wr_en   = f0_wr_pend_reg;
        f1_wr_data = pix_data;
        f0_wr_data = f1_rd_data;
        // A write into a full FIFO is fine when the same FIFO is popped in the same cycle.
        err_next   = (f1_wr_en & f1_full & ~f1_rd_en) |
                     (f0_wr_en & f0_full & ~f0_rd_en) |
                     (f1_rd_en & f1_empty) |
                     (f0_rd_en & f0_empty) |
                     ((state_reg == DONE) & ~(f0_empty & f1_empty));
    end

    // FIFO read data is only valid the cycle after the read, so it is passed straight
    // through while col_valid is high and captured for holding afterwards.
    assign pix_ready  = pix_ready_reg;
    assign col_valid  = col_valid_reg;
    assign col_top    = col_valid_reg ? f0_rd_data : col_top_hold_reg;
    assign col_mid    = col_valid_reg ? f1_rd_data : col_mid_hold_reg;
    assign col_bot    = col_bot_reg;
    assign col_x      = col_x_reg;
    assign row_y      = row_y_reg;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            x_reg            <= '0;
            y_reg            <= '0;
            pix_ready_reg    <= 1'b0;
            f0_wr_pend_reg   <= 1'b0;
            col_valid_reg    <= 1'b0;
            frame_done_reg   <= 1'b0;
            err_reg          <= 1'b0;
            col_bot_reg      <= '0;
            col_top_hold_reg <= '0;
            col_mid_hold_reg <= '0;
            col_x_reg        <= '0;
            row_y_reg        <= '0;
        end else begin
            f0_wr_pend_reg <= xfer & ((state_reg == ROW1) | (in_steady & ~last_row));
            col_valid_reg  <= xfer & in_steady;
            frame_done_reg <= 1'b0;
            if (err_next) begin
                err_reg <= 1'b1;
            end
            if (xfer & in_steady) begin
                col_bot_reg <= pix_data;
                col_x_reg   <= 4'(x_reg);
                row_y_reg   <= y_reg;
            end
            if (col_valid_reg) begin
                col_top_hold_reg <= f0_rd_data;
                col_mid_hold_reg <= f1_rd_data;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= ROW0;
                        x_reg         <= '0;
                        y_reg         <= '0;
                        pix_ready_reg <= 1'b1;
                    end
                end
                ROW0, ROW1, STEADY: begin
                    if (xfer) begin
                        if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 8'd1;
                            if (state_reg == ROW0) begin
                                state_reg <= ROW1;
                            end else if (state_reg == ROW1) begin
                                state_reg <= STEADY;
                            end else if (last_row) begin
                                state_reg      <= DONE;
                                pix_ready_reg  <= 1'b0;
                                frame_done_reg <= 1'b1;
                            end
                        end else begin
                            x_reg <= x_reg + XW'(1);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg     <= IDLE;
                    pix_ready_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_linebuf_ctrl.sv
// Randomized bench for conv_linebuf_ctrl: two instances (8x8 and 16x3) with behavioural
// row FIFOs, a column scoreboard built from the frame image, and control/flag checks.
module tb_conv_linebuf_ctrl;
    localparam int DW = 16;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [NI];
    logic          start      [NI];
    logic          pix_valid  [NI];
    logic [DW-1:0] pix_data   [NI];
    logic          force_full [NI];
    logic          pix_ready  [NI];
    logic          f1_wr_en   [NI];
    logic          f1_rd_en   [NI];
    logic          f0_wr_en   [NI];
    logic          f0_rd_en   [NI];
    logic [DW-1:0] f1_wr_data [NI];
    logic [DW-1:0] f0_wr_data [NI];
    logic          f1_full    [NI];
    logic          f1_empty   [NI];
    logic          f0_full    [NI];
    logic          f0_empty   [NI];
    logic          col_valid  [NI];
    logic [DW-1:0] col_top    [NI];
    logic [DW-1:0] col_mid    [NI];
    logic [DW-1:0] col_bot    [NI];
    logic [3:0]    col_x      [NI];
    logic [7:0]    row_y      [NI];
    logic          frame_done [NI];
    logic          err        [NI];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_cols   [NI];
    logic          mon_en   = 1'b0;
    logic [47:0]   cap32    = '0;
    logic [63:0]   exp_q    [NI][$];
    logic [DW-1:0] img      [8][16];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 8 : 16;
        localparam int H = (gi == 0) ? 8 : 3;

        logic [DW-1:0] f1_rd_data;
        logic [DW-1:0] f0_rd_data;
        logic [DW-1:0] mem1 [16];
        logic [DW-1:0] mem0 [16];
        int            cnt1, wp1, rp1, cnt0, wp0, rp0;
        logic          rd1, wr1, rd0, wr0;
        logic          prev_xfer = 1'b0;

        conv_linebuf_ctrl #(
            .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(16)
        ) u_dut (
            .clk(clk), .rst(rst[gi]), .start(start[gi]),
            .pix_data(pix_data[gi]), .pix_valid(pix_valid[gi]), .pix_ready(pix_ready[gi]),
            .f1_wr_en(f1_wr_en[gi]), .f1_wr_data(f1_wr_data[gi]), .f1_rd_en(f1_rd_en[gi]),
            .f1_rd_data(f1_rd_data),
            .f0_wr_en(f0_wr_en[gi]), .f0_wr_data(f0_wr_data[gi]), .f0_rd_en(f0_rd_en[gi]),
            .f0_rd_data(f0_rd_data),
            .f1_full(f1_full[gi]), .f1_empty(f1_empty[gi]),
            .f0_full(f0_full[gi]), .f0_empty(f0_empty[gi]),
            .col_valid(col_valid[gi]), .col_top(col_top[gi]), .col_mid(col_mid[gi]),
            .col_bot(col_bot[gi]), .col_x(col_x[gi]), .row_y(row_y[gi]),
            .frame_done(frame_done[gi]), .err(err[gi])
        );

        // Behavioural 16-deep FIFOs with read data registered one cycle after rd_en.
        assign rd1 = f1_rd_en[gi] && (cnt1 > 0);
        assign wr1 = f1_wr_en[gi] && ((cnt1 < 16) || rd1);
        assign rd0 = f0_rd_en[gi] && (cnt0 > 0);
        assign wr0 = f0_wr_en[gi] && ((cnt0 < 16) || rd0);
        assign f1_full[gi]  = (cnt1 == 16) || force_full[gi];
        assign f1_empty[gi] = (cnt1 == 0);
        assign f0_full[gi]  = (cnt0 == 16);
        assign f0_empty[gi] = (cnt0 == 0);

        always @(posedge clk) begin
            if (rst[gi]) begin
                cnt1 <= 0; wp1 <= 0; rp1 <= 0; f1_rd_data <= '0;
                cnt0 <= 0; wp0 <= 0; rp0 <= 0; f0_rd_data <= '0;
            end else begin
                if (wr1) begin mem1[wp1] <= f1_wr_data[gi]; wp1 <= (wp1 + 1) % 16; end
                if (rd1) begin f1_rd_data <= mem1[rp1]; rp1 <= (rp1 + 1) % 16; end
                cnt1 <= cnt1 + (wr1 ? 1 : 0) - (rd1 ? 1 : 0);
                if (wr0) begin mem0[wp0] <= f0_wr_data[gi]; wp0 <= (wp0 + 1) % 16; end
                if (rd0) begin f0_rd_data <= mem0[rp0]; rp0 <= (rp0 + 1) % 16; end
                cnt0 <= cnt0 + (wr0 ? 1 : 0) - (rd0 ? 1 : 0);
            end
        end

        // Column monitor: every col_valid must follow an accepted pixel and match the scoreboard.
        always @(negedge clk) begin
            if (mon_en) begin
                if (col_valid[gi] === 1'b1) begin
                    n_cols[gi]++;
                    $display("inst%0d col x=%0d y=%0d top=%h mid=%h bot=%h done=%0b",
                             gi, col_x[gi], row_y[gi], col_top[gi], col_mid[gi], col_bot[gi],
                             frame_done[gi]);
                    check_eq("col_after_xfer", prev_xfer, 1);
                    check_eq("col_expected", exp_q[gi].size() > 0, 1);
                    if (exp_q[gi].size() > 0) begin
                        check_eq("col_value",
                                 {3'b000, col_top[gi], col_mid[gi], col_bot[gi], col_x[gi],
                                  row_y[gi], frame_done[gi]},
                                 exp_q[gi].pop_front());
                    end
                    if (gi == 0 && col_x[gi] == 4'd3 && row_y[gi] == 8'd2) begin
                        cap32 <= {col_top[gi], col_mid[gi], col_bot[gi]};
                    end
                end else if (frame_done[gi] === 1'b1) begin
                    check_eq("frame_done_without_col", frame_done[gi], 0);
                end
                prev_xfer <= pix_valid[gi] & pix_ready[gi];
            end
        end
    end

    function automatic int img_w(input int inst);
        return (inst == 0) ? 8 : 16;
    endfunction

    function automatic int img_h(input int inst);
        return (inst == 0) ? 8 : 3;
    endfunction

    task automatic fill_img(input int inst, input bit ramp);
        for (int y = 0; y < img_h(inst); y++)
            for (int x = 0; x < img_w(inst); x++)
                img[y][x] = ramp ? 16'(y * 16 + x) : 16'($urandom);
    endtask

    // Expected columns: rows y-2/y-1/y of the image for every pixel from row 2 on,
    // limited to the pixels actually sent.
    task automatic build_expected(input int inst, input int limit);
        int   w, h;
        logic done;
        w = img_w(inst);
        h = img_h(inst);
        for (int y = 2; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y * w + x < limit) begin
                    done = (x == w - 1) && (y == h - 1);
                    exp_q[inst].push_back({3'b000, img[y-2][x], img[y-1][x], img[y][x],
                                           4'(x), 8'(y), done});
                end
            end
        end
    endtask

    // mode 0: back-to-back, 1: alternating valid, 2: random gaps
    task automatic run_pixels(input int inst, input int mode, input int from, input int to,
                              input int spur_idx, input int force_idx);
        int w, gaps;
        w = img_w(inst);
        if (from == 0) begin
            start[inst] = 1'b1;
            @(posedge clk); #1;
            start[inst] = 1'b0;
            check_eq("ready_after_start", pix_ready[inst], 1);
        end
        for (int idx = from; idx < to; idx++) begin
            gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (gaps) begin
                pix_valid[inst] = 1'b0;
                @(posedge clk); #1;
            end
            pix_valid[inst]  = 1'b1;
            pix_data[inst]   = img[idx / w][idx % w];
            start[inst]      = (idx == spur_idx);
            force_full[inst] = (idx == force_idx);
            @(posedge clk); #1;
            pix_valid[inst]  = 1'b0;
            start[inst]      = 1'b0;
            force_full[inst] = 1'b0;
        end
    endtask

    task automatic end_checks(input int inst, input logic exp_err, input int exp_cols);
        repeat (4) @(posedge clk);
        #1;
        check_eq("cols_outstanding", exp_q[inst].size(), 0);
        check_eq("col_count", n_cols[inst], exp_cols);
        check_eq("fifos_empty", {f1_empty[inst], f0_empty[inst]}, 2'b11);
        check_eq("err_flag", err[inst], exp_err);
        check_eq("idle_not_ready", pix_ready[inst], 0);
    endtask

    task automatic check_reset_outputs(input int inst);
        check_eq("rst_ctrl", {pix_ready[inst], col_valid[inst], frame_done[inst], err[inst],
                              f1_wr_en[inst], f1_rd_en[inst], f0_wr_en[inst], f0_rd_en[inst]}, 0);
        check_eq("rst_cols", {col_top[inst], col_mid[inst], col_bot[inst], col_x[inst],
                              row_y[inst]}, 0);
    endtask

    task automatic full_frame(input int inst, input bit ramp, input int mode, input int spur_idx);
        if (!ramp || inst != 0) fill_img(inst, ramp);
        else fill_img(inst, 1'b1);
        build_expected(inst, img_w(inst) * img_h(inst));
        n_cols[inst] = 0;
        run_pixels(inst, mode, 0, img_w(inst) * img_h(inst), spur_idx, -1);
        end_checks(inst, 1'b0, img_w(inst) * (img_h(inst) - 2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; pix_valid[i] = 1'b0;
            pix_data[i] = '0; force_full[i] = 1'b0; n_cols[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_reset_outputs(i);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        mon_en = 1'b1;

        // 8x8 ramp, back-to-back; known column at (3,2)
        full_frame(0, 1'b1, 0, -1);
        check_eq("col_3_2", cap32, {16'h0003, 16'h0013, 16'h0023});
        // Same frame with pix_valid alternating, then a plain restart
        full_frame(0, 1'b1, 1, -1);
        full_frame(0, 1'b1, 0, -1);
        // Random pixels, random gaps, spurious start in the middle of row 3
        full_frame(0, 1'b0, 2, 3 * 8 + 2);

        // Reset in the middle of row 4 at x=5
        fill_img(0, 1'b1);
        build_expected(0, 4 * 8 + 5);
        n_cols[0] = 0;
        run_pixels(0, 0, 0, 4 * 8 + 5, -1, -1);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs(0);
        check_eq("rst_flush", {f1_empty[0], f0_empty[0]}, 2'b11);
        rst[0] = 1'b0;
        check_eq("abort_cols_left", exp_q[0].size(), 0);
        check_eq("abort_col_count", n_cols[0], 2 * 8 + 5);
        full_frame(0, 1'b1, 2, -1);

        // 16-wide rows fill FIFO1 exactly without an error
        fill_img(1, 1'b0);
        build_expected(1, 48);
        n_cols[1] = 0;
        run_pixels(1, 0, 0, 32, -1, -1);
        check_eq("w16_f1_full", f1_full[1], 1);
        check_eq("w16_no_err", err[1], 0);
        run_pixels(1, 0, 32, 48, -1, -1);
        end_checks(1, 1'b0, 16);
        full_frame(1, 1'b0, 2, -1);

        // Forced full flag during a row-0 write sets a sticky error
        fill_img(1, 1'b0);
        build_expected(1, 48);
        n_cols[1] = 0;
        run_pixels(1, 2, 0, 48, -1, 3);
        end_checks(1, 1'b1, 16);
        repeat (5) @(posedge clk);
        #1;
        check_eq("err_sticky", err[1], 1);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        check_eq("err_cleared", err[1], 0);
        rst[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
